// File: rtl/index_vector_assembler.sv
// Rebuilds a one-hot-OR vector from a stream of descending bit indices and
// presents it, with beat count and an ordering-error flag, once per frame.
module index_vector_assembler #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<IDX_W)-1:0] out_vec,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_err
);
  localparam int N = 1 << IDX_W;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_reg;
  logic             first_reg;
  logic [IDX_W-1:0] prev_idx_reg;
  logic [N-1:0]     onehot;
  logic             accept;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign onehot[gi] = (in_idx == IDX_W'(gi));
    end
  endgenerate

  // in_ready depends on state only, so out_ready never reaches it combinationally
  assign in_ready = (state_reg == COLLECT);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= COLLECT;
      out_valid    <= 1'b0;
      out_vec      <= '0;
      out_count    <= '0;
      out_err      <= 1'b0;
      first_reg    <= 1'b1;
      prev_idx_reg <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            out_vec <= out_vec | onehot;
            if (out_count != {CNT_W{1'b1}})
              out_count <= out_count + CNT_W'(1);
            // equal indices count as a violation, so duplicates flag too
            if (!first_reg && (in_idx >= prev_idx_reg))
              out_err <= 1'b1;
            prev_idx_reg <= in_idx;
            first_reg    <= 1'b0;
            if (in_last) begin
              state_reg <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg <= COLLECT;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            first_reg <= 1'b1;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_index_vector_assembler.sv
// Self-checking bench for index_vector_assembler: directed scenarios plus
// random frames produced by a behavioural priority-encoder source.
module tb_index_vector_assembler;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] in_idx = '0;
    logic             in_ready, out_valid, out_err;
    logic [N-1:0]     out_vec;
    logic [CNT_W-1:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    index_vector_assembler #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_count(out_count), .out_err(out_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: vector is the OR of decoded indices, count saturates,
    // error when any beat is not strictly below its predecessor.
    function automatic void model(input int idxs[$], output logic [N-1:0] v,
                                  output logic [CNT_W-1:0] c, output logic e);
        int lim;
        lim = (1 << CNT_W) - 1;
        v = '0;
        e = 1'b0;
        foreach (idxs[i]) begin
            v = v | N'(1 << idxs[i]);
            if (i > 0 && idxs[i] >= idxs[i-1]) e = 1'b1;
        end
        c = CNT_W'((idxs.size() > lim) ? lim : idxs.size());
    endfunction

    task automatic send_beat(input int idx, input bit last, input int gap, output bit ok);
        ok = 1'b1;
        repeat (gap) step();
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_last  = last;
        for (int t = 0; !in_ready; t++) begin
            if (t > 50) begin
                ok = 1'b0;
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_idx   = 'x;
    endtask

    task automatic send_frame(input int idxs[$], input int gap_max, output bit ok);
        bit b;
        ok = 1'b1;
        foreach (idxs[i]) begin
            send_beat(idxs[i], (i == idxs.size() - 1), $urandom_range(0, gap_max), b);
            ok = ok & b;
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_cmp++;
        if ({in_ready, out_valid, out_vec, out_count, out_err} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: got rdy=%b vld=%b vec=%h cnt=%0d err=%b required rdy=1 vld=0 vec=00 cnt=0 err=0",
                     in_ready, out_valid, out_vec, out_count, out_err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int q[$];
        bit ok;
        logic [N-1:0] ev; logic [CNT_W-1:0] ec; logic ee;
        q = '{7, 4, 0};
        model(q, ev, ec, ee);
        send_frame(q, 0, ok);
        n_cmp++;
        if (!ok || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency: got out_valid=%b ok=%b required out_valid=1", out_valid, ok);
        end
        n_cmp++;
        if ({out_vec, out_count, out_err} !== {8'b1001_0001, 4'd3, 1'b0} || {ev, ec, ee} !== {8'b1001_0001, 4'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_frame: got vec=%b cnt=%0d err=%b required vec=%b cnt=%0d err=%b",
                     out_vec, out_count, out_err, ev, ec, ee);
        end
        handshake();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_release: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        bit ok;
        send_beat(5, 1'b1, 0, ok);
        in_valid = 1'b1; in_idx = 3'd6; in_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({out_valid, in_ready, out_vec, out_count} !== {1'b1, 1'b0, 8'b0010_0000, 4'd1}) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b vec=%b cnt=%0d required vld=1 rdy=0 vec=00100000 cnt=1",
                         k, out_valid, in_ready, out_vec, out_count);
            end
            step();
        end
        handshake();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_ready_after: got rdy=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0; in_last = 1'b0; in_idx = 'x;
        n_cmp++;
        if ({out_valid, out_vec, out_count, out_err} !== {1'b1, 8'b0100_0000, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_pending_beat: got vld=%b vec=%b cnt=%0d err=%b required vld=1 vec=01000000 cnt=1 err=0",
                     out_valid, out_vec, out_count, out_err);
        end
        handshake();
    endtask

    task automatic test_err_sticky();
        int q[$];
        bit ok;
        logic [N-1:0] ev; logic [CNT_W-1:0] ec; logic ee;
        q = '{3, 6};
        model(q, ev, ec, ee);
        send_frame(q, 1, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {ev, ec, ee} || ev !== 8'b0100_1000 || ee !== 1'b1) begin
            n_bad++;
            $display("FAIL err_ascending: got vec=%b cnt=%0d err=%b required vec=%b cnt=%0d err=%b",
                     out_vec, out_count, out_err, ev, ec, ee);
        end
        handshake();
        q = '{2};
        model(q, ev, ec, ee);
        send_frame(q, 1, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {ev, ec, ee}) begin
            n_bad++;
            $display("FAIL err_cleared: got vec=%b cnt=%0d err=%b required vec=%b cnt=%0d err=%b",
                     out_vec, out_count, out_err, ev, ec, ee);
        end
        handshake();
    endtask

    task automatic test_long_frames();
        int q[$];
        bit ok;
        logic [N-1:0] ev; logic [CNT_W-1:0] ec; logic ee;
        // nine beats (duplicate zero at the end), then a frame that saturates the counter
        q = '{7, 6, 5, 4, 3, 2, 1, 0, 0};
        model(q, ev, ec, ee);
        send_frame(q, 0, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {8'hFF, 4'd9, 1'b1} || {ev, ec, ee} !== {8'hFF, 4'd9, 1'b1}) begin
            n_bad++;
            $display("FAIL nine_beats: got vec=%h cnt=%0d err=%b required vec=ff cnt=9 err=1",
                     out_vec, out_count, out_err);
        end
        handshake();
        q = '{};
        for (int i = 0; i < 18; i++) q.push_back((i < 8) ? 7 - i : $urandom_range(0, 7));
        model(q, ev, ec, ee);
        send_frame(q, 0, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {ev, ec, ee} || ec !== 4'd15) begin
            n_bad++;
            $display("FAIL saturate: got vec=%h cnt=%0d err=%b required vec=%h cnt=%0d err=%b",
                     out_vec, out_count, out_err, ev, ec, ee);
        end
        handshake();
        q = '{0};
        send_frame(q, 0, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {8'b0000_0001, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL idx0_single: got vec=%b cnt=%0d err=%b required vec=00000001 cnt=1 err=0",
                     out_vec, out_count, out_err);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        int q[$];
        bit ok;
        send_beat(7, 1'b0, 0, ok);
        send_beat(2, 1'b0, 0, ok);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_vec, out_count, in_ready, out_valid} !== {8'h00, 4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got vec=%h cnt=%0d rdy=%b vld=%b required vec=00 cnt=0 rdy=1 vld=0",
                     out_vec, out_count, in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        q = '{1};
        send_frame(q, 0, ok);
        n_cmp++;
        if (!ok || {out_vec, out_count, out_err} !== {8'b0000_0010, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL after_reset: got vec=%b cnt=%0d err=%b required vec=00000010 cnt=1 err=0",
                     out_vec, out_count, out_err);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int idx;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idx    = $urandom_range(0, 7);
            in_idx = IDX_W'(idx);
            step();
            n_cmp++;
            if ({out_valid, in_ready, out_vec, out_count} !== {1'b1, 1'b0, N'(1 << idx), 4'd1}) begin
                n_bad++;
                $display("FAIL b2b_out[%0d]: got vld=%b rdy=%b vec=%b cnt=%0d required vld=1 rdy=0 vec=%b cnt=1",
                         k, out_valid, in_ready, out_vec, out_count, N'(1 << idx));
            end
            step();
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_bad++;
                $display("FAIL b2b_release[%0d]: got vld=%b rdy=%b required vld=0 rdy=1", k, out_valid, in_ready);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_idx = 'x;
    endtask

    task automatic test_random();
        int q[$];
        bit ok, got;
        logic [N-1:0] src;
        for (int f = 0; f < 40; f++) begin
            src = N'($urandom_range(1, 255));
            q = '{};
            for (int b = N - 1; b >= 0; b--) if (src[b]) q.push_back(b);
            out_ready = 1'($urandom_range(0, 1));
            send_frame(q, 2, ok);
            out_ready = 1'b0;
            wait_out(got);
            repeat ($urandom_range(0, 3)) step();
            n_cmp++;
            if (!ok || !got || {out_vec, out_count, out_err} !== {src, CNT_W'($countones(src)), 1'b0}) begin
                n_bad++;
                $display("FAIL random[%0d]: got vec=%b cnt=%0d err=%b vld=%b required vec=%b cnt=%0d err=0",
                         f, out_vec, out_count, out_err, out_valid, src, $countones(src));
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_err_sticky();
        test_long_frames();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/index_vector_assembler.md
Name: index_vector_assembler

Overview:
- Inverse of the 8:3 priority encoder.
- Accepts a serial stream of 3-bit indices over a valid/ready handshake. Each index is decoded one-hot and ORed into an 8-bit vector.
- On the frame's last beat, it presents the rebuilt vector, beat count and an ordering-error flag over a valid/ready output handshake.
- Sits downstream of an iterative encoder that strips the highest set bit per cycle and emits indices strictly descending.

Parameters:
- IDX_W, 3, index width; vector width N = 2**IDX_W (8 at default).
- CNT_W, 4, beat-counter width; counter saturates at 2**CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  index beat valid.
- in_ready  output  1  block can accept a beat.
- in_idx  input  IDX_W  index of a set bit.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  assembled frame available.
- out_ready  input  1  consumer accepts the frame.
- out_vec  output  N  reconstructed vector.
- out_count  output  CNT_W  number of beats accepted in the frame.
- out_err  output  1  frame violated strict-descending order (includes duplicates).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low (rst_n), released synchronously by the integrator.
- Reset values:
  - state=COLLECT, in_ready=1, out_valid=0.
  - out_vec=0, out_count=0, out_err=0.
  - first-beat flag=1, prev_idx=0.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid&in_ready.
  - On accept: vec <= vec | (1<<in_idx); count <= count+1, saturating at 2**CNT_W-1.
  - If not the first beat and in_idx >= prev_idx, err <= 1. err is sticky for the frame.
  - On accept: prev_idx <= in_idx, first <= 0.
  - Accept with in_last=1 -> HOLD. Updates from that beat are included in the output.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_vec, out_count and out_err are stable until out_valid&out_ready.
  - On handshake: clear vec, count, err; set first=1; go to COLLECT.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible the cycle after the in_last handshake.
- Throughput: a one-beat frame followed by an immediate out_ready gives one frame per 2 cycles. There is no combinational path from out_ready to in_ready, and no bypass.
- Boundary conditions:
  - in_valid in HOLD is ignored. The beat is not consumed; the producer must hold it until in_ready=1.
  - out_ready in COLLECT has no effect.
  - A 9th beat in one frame necessarily violates ordering, so err=1; the vector stays the OR of all indices.
  - Duplicate index: err=1, vector unchanged by that bit.
  - in_idx=0 as a first and last beat is legal: vec=8'b0000_0001, count=1, err=0.
  - X/Z on in_idx while in_valid=0 must not affect state.
  - rst_n asserted mid-frame or in HOLD clears everything immediately (asynchronously). out_valid drops without a handshake.
- All outputs are driven directly from registers, except in_ready, which is decoded from state only.

Test Plan:
1. Reset then beats 7,4,0 (last on 0), out_ready=1 -> out_valid the cycle after the 3rd beat; out_vec=8'b1001_0001, out_count=3, out_err=0; in_ready=1 the cycle after the handshake.
2. Single beat idx=5 last, out_ready held 0 for 4 cycles -> out_vec=8'b0010_0000, count=1 stable across all 4 cycles; in_ready=0; an in_valid beat of idx=6 is not consumed until after the handshake.
3. Beats 3,6 (last) -> out_vec=8'b0100_1000, count=2, out_err=1. Next frame of beat 2 (last) -> out_vec=8'b0000_0100, err=0 (sticky err cleared).
4. Beats 7,6,5,4,3,2,1,0,0 (last on 9th) -> out_vec=8'hFF, count=9, err=1.
5. rst_n pulsed low for half a cycle after beats 7,2 (no last) -> out_vec=0, count=0, in_ready=1 immediately. Subsequent frame 1 (last) -> out_vec=8'b0000_0010, err=0.
6. Random back-to-back frames from a model priority encoder fed $random vectors, random in_valid/out_ready stalls -> every out_vec equals the source vector, out_count equals its popcount, out_err=0.
